dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//   Shares the single data port of the unified RAM between two requesters:
//   m0 = core load/store unit, m1 = program loader / debug DMA. Picks one
//   request per cycle, drives the RAM data port, returns read data one cycle
//   later. Bounded-burst fairness: neither master starves the other.
// PARAMETERS
//   DATA_WIDTH  32  data word width, matches RAM
//   ADDR_WIDTH  16  byte address width, matches RAM
//   MAX_BURST    4  max consecutive grants to one master while the other waits (>=1)
// PORTS
//   clock      in   1    system clock, all state on posedge
//   reset      in   1    asynchronous, active-high
//   m0_req     in   1    m0 access request, held until granted
//   m0_we      in   1    1 = write, 0 = read
//   m0_addr    in   AW   byte address
//   m0_wdata   in   DW   write data
//   m0_gnt     out  1    request accepted this cycle
//   m0_rvalid  out  1    read data valid (cycle after read grant)
//   m0_rdata   out  DW   read data
//   m1_*       same set as m0_* for master 1
//   mem_wEn    out  1    to RAM wEn
//   mem_addr   out  AW   to RAM d_address
//   mem_wdata  out  DW   to RAM d_write_data
//   mem_rdata  in   DW   from RAM d_read_data (combinational)
// BEHAVIOUR
// - Reset (async, immediate): state IDLE, burst_cnt 0, rvalid both 0, rdata both 0.
//   While reset high: both gnt 0, mem_wEn 0, mem_addr/mem_wdata 0.
// - Grant is combinational from req + registered state; at most one gnt per cycle.
// - Granted master's we/addr/wdata muxed to mem_*; mem_wEn = granted & we.
//   No grant: mem_wEn 0, mem_addr 0, mem_wdata 0. Address passed unmodified.
// - Write: committed by RAM on the posedge ending the grant cycle; no rvalid.
// - Read: mem_rdata captured into mX_rdata at that posedge; mX_rvalid high for
//   exactly the next cycle. rdata holds last value when rvalid low.
// - Fully pipelined: one access per cycle; rvalid of access N overlaps grant of N+1.
// - FSM states IDLE, OWN0, OWN1; burst_cnt saturates at MAX_BURST:
//   IDLE: m0_req -> gnt m0, OWN0, cnt=1 (tie -> m0); else m1_req -> gnt m1, OWN1, cnt=1.
//   OWN0: m0_req & (!m1_req | cnt<MAX_BURST) -> gnt m0, cnt++;
//         else m1_req -> gnt m1, OWN1, cnt=1; else no gnt, IDLE, cnt=0.
//   OWN1: symmetric with m0/m1 swapped.
// - Burst limit only forces a switch when the other master is requesting; a lone
//   requester is granted every cycle indefinitely.
// - Requests must hold stable until gnt; dropping req before gnt is legal (no access).
// - Reset mid-read: pending rvalid cleared, data lost; writes already committed stay.
// TESTING
// - Reset, m0 read addr 0x0010 (RAM word 4 = 0xDEADBEEF) -> m0_gnt same cycle,
//   m0_rvalid=1 and m0_rdata=0xDEADBEEF next cycle only.
// - m0 write 0x1234_5678 then m1 read same address back-to-back -> m1_rdata=0x12345678.
// - Both req continuously, MAX_BURST=4, starting IDLE -> grant sequence
//   m0,m0,m0,m0,m1,m1,m1,m1,m0..., never two gnt in one cycle.
// - Only m1 requests for 10 cycles -> 10 consecutive m1 grants, no switch, no gaps.
// - Assert reset during m0 read grant cycle -> gnt/mem_wEn 0 at once,
//   m0_rvalid 0 next cycle, state IDLE after release.
// - Idle cycles (no req) -> mem_wEn 0, mem_addr 0, both rvalid 0, state returns IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the unified RAM data port between the core LSU (m0)
// and the loader/debug DMA (m1). One access per cycle, read data returned one
// cycle after the grant, bounded-burst fairness between the two masters.
module dmem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  mem_wEn,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Counter must hold 0..MAX_BURST inclusive.
    localparam int unsigned CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             gnt0;
    logic             gnt1;
    logic             burst_open;
    logic [CNT_W-1:0] cnt_inc;

    // Current owner may keep the port while its burst budget is not used up.
    assign burst_open = (burst_cnt < CNT_MAX);
    assign cnt_inc    = burst_open ? (burst_cnt + CNT_ONE) : burst_cnt;

    // Ownership state and burst counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= CNT_ZERO;
        end else begin
            state     <= next_state;
            burst_cnt <= next_cnt;
        end
    end

    // Arbitration: grant decision and next ownership from requests and state.
    always_comb begin
        next_state = state;
        next_cnt   = burst_cnt;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req) begin
                    gnt0       = 1'b1;
                    next_state = OWN0;
                    next_cnt   = CNT_ONE;
                end else if (m1_req) begin
                    gnt1       = 1'b1;
                    next_state = OWN1;
                    next_cnt   = CNT_ONE;
                end else begin
                    next_state = IDLE;
                    next_cnt   = CNT_ZERO;
                end
            end
            OWN0: begin
                if (m0_req && (!m1_req || burst_open)) begin
                    gnt0     = 1'b1;
                    next_cnt = cnt_inc;
                end else if (m1_req) begin
                    gnt1       = 1'b1;
                    next_state = OWN1;
                    next_cnt   = CNT_ONE;
                end else begin
                    next_state = IDLE;
                    next_cnt   = CNT_ZERO;
                end
            end
            OWN1: begin
                if (m1_req && (!m0_req || burst_open)) begin
                    gnt1     = 1'b1;
                    next_cnt = cnt_inc;
                end else if (m0_req) begin
                    gnt0       = 1'b1;
                    next_state = OWN0;
                    next_cnt   = CNT_ONE;
                end else begin
                    next_state = IDLE;
                    next_cnt   = CNT_ZERO;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = CNT_ZERO;
            end
        endcase
        // Nothing reaches the RAM while reset is held.
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // RAM data port mux; idle port drives zeros.
    always_comb begin
        mem_wEn   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_wEn   = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_wEn   = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // m0 read return: capture RAM data at the end of the read grant cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt0 & ~m0_we;
            if (gnt0 && !m0_we) begin
                m0_rdata <= mem_rdata;
            end
        end
    end

    // m1 read return: capture RAM data at the end of the read grant cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m1_rvalid <= gnt1 & ~m1_we;
            if (gnt1 && !m1_we) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: RAM model, reference arbiter model,
// scoreboard queues and a negedge monitor.
module tb_dmem_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int MAXB = 4;
    localparam int WORDS = 16384;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_wEn;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // RAM the arbiter talks to: combinational read, write on posedge.
    logic [DW-1:0] ram [WORDS];
    assign mem_rdata = ram[mem_addr[AW-1:2]];
    always @(posedge clock) begin
        if (mem_wEn) ram[mem_addr[AW-1:2]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int g; logic wen; logic [AW-1:0] addr; logic [DW-1:0] wdata; } gexp_t;
    typedef struct { int due; logic [DW-1:0] data; } rexp_t;

    gexp_t gq[$];
    rexp_t rq0[$];
    rexp_t rq1[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [DW-1:0] last_rd0 = '0;
    logic [DW-1:0] last_rd1 = '0;

    // Reference state: memory contents and grant history (last owner, run length).
    logic [DW-1:0] shadow [WORDS];
    int m_last = -1;
    int m_run = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Who should win this cycle, from the fairness rules over grant history.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
            if (m_last < 0) return 0;
            if (m_run < MAXB) return m_last;
            return 1 - m_last;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic void record(input int g);
        if (g < 0) begin
            m_last = -1;
            m_run  = 0;
        end else if (g == m_last) begin
            if (m_run < MAXB) m_run++;
        end else begin
            m_last = g;
            m_run  = 1;
        end
    endfunction

    // One cycle of stimulus; expected grant/port values and read data go to the queues.
    task automatic drive_cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               output int g);
        gexp_t e;
        rexp_t r;
        @(posedge clock);
        #1;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        g = pick(r0, r1);
        record(g);
        e.g = g; e.wen = 1'b0; e.addr = '0; e.wdata = '0;
        if (g >= 0) begin
            e.wen   = (g == 0) ? w0 : w1;
            e.addr  = (g == 0) ? a0 : a1;
            e.wdata = (g == 0) ? d0 : d1;
            if (e.wen) begin
                shadow[e.addr[AW-1:2]] = e.wdata;
            end else begin
                r.due  = cyc + 1;
                r.data = shadow[e.addr[AW-1:2]];
                if (g == 0) rq0.push_back(r);
                else        rq1.push_back(r);
            end
        end
        gq.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        int g;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, '0, 0, 0, '0, '0, g);
    endtask

    // Monitor: compare port activity and read returns against the queued expectations.
    always @(negedge clock) begin
        gexp_t e;
        rexp_t r;
        if (mon_en) begin
            chk("dual_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
            chk("gnt_q_depth", 32'(gq.size()), 32'd1);
            if (gq.size() > 0) begin
                e = gq.pop_front();
                chk("m0_gnt", 32'(m0_gnt), 32'(e.g == 0));
                chk("m1_gnt", 32'(m1_gnt), 32'(e.g == 1));
                chk("mem_wEn", 32'(mem_wEn), 32'(e.wen));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_wdata", mem_wdata, e.wdata);
            end
            if (m0_rvalid) begin
                if (rq0.size() == 0) chk("m0_rvalid_spurious", 32'(m0_rvalid), 32'd0);
                else begin
                    r = rq0.pop_front();
                    chk("m0_rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("m0_rdata", m0_rdata, r.data);
                    last_rd0 = r.data;
                end
            end else begin
                if (rq0.size() > 0 && rq0[0].due <= cyc) begin
                    r = rq0.pop_front();
                    chk("m0_rvalid_missing", 32'(m0_rvalid), 32'd1);
                end
                chk("m0_rdata_hold", m0_rdata, last_rd0);
            end
            if (m1_rvalid) begin
                if (rq1.size() == 0) chk("m1_rvalid_spurious", 32'(m1_rvalid), 32'd0);
                else begin
                    r = rq1.pop_front();
                    chk("m1_rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("m1_rdata", m1_rdata, r.data);
                    last_rd1 = r.data;
                end
            end else begin
                if (rq1.size() > 0 && rq1[0].due <= cyc) begin
                    r = rq1.pop_front();
                    chk("m1_rvalid_missing", 32'(m1_rvalid), 32'd1);
                end
                chk("m1_rdata_hold", m1_rdata, last_rd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit p0, p1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        for (int i = 0; i < WORDS; i++) begin
            ram[i]    = 32'hA500_0000 | 32'(i);
            shadow[i] = 32'hA500_0000 | 32'(i);
        end
        ram[4]    = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;

        // Reset: outputs quiet even with requests present.
        m0_req = 1'b1; m0_addr = 16'h0010; m1_req = 1'b1; m1_addr = 16'h0020;
        #3;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_wEn", 32'(mem_wEn), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        #1 mon_en = 1'b1;

        // Directed: read of word 4, then write followed by read from the other master.
        drive_cycle(1, 0, 16'h0010, '0, 0, 0, '0, '0, g);
        idle_cycles(1);
        drive_cycle(1, 1, 16'h0040, 32'h1234_5678, 0, 0, '0, '0, g);
        drive_cycle(0, 0, '0, '0, 1, 0, 16'h0040, '0, g);
        idle_cycles(2);

        // Both masters requesting continuously: bursts of MAXB alternate.
        for (int i = 0; i < 18; i++)
            drive_cycle(1, 0, 16'(32'h100 + 4 * i), '0, 1, 0, 16'(32'h200 + 4 * i), '0, g);
        idle_cycles(2);

        // Lone m1 requester is never cut off.
        for (int i = 0; i < 10; i++)
            drive_cycle(0, 0, '0, '0, 1, i[0], 16'(32'h300 + 4 * i), 32'(i), g);
        idle_cycles(3);

        // Reset asserted during an m0 read grant cycle.
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        #2;
        chk("pre_rst_m0_gnt", 32'(m0_gnt), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("midrst_mem_wEn", 32'(mem_wEn), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clock);
        #1;
        chk("midrst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        @(negedge clock);
        reset = 1'b0; m0_req = 1'b0;
        gq.delete(); rq0.delete(); rq1.delete();
        last_rd0 = '0; last_rd1 = '0;
        m_last = -1; m_run = 0;
        #1 mon_en = 1'b1;
        for (int i = 0; i < 6; i++)
            drive_cycle(1, 0, 16'h0010, '0, 1, 0, 16'h0014, '0, g);
        idle_cycles(3);

        // Random traffic: requests held until granted, occasional withdrawals.
        p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 2000; i++) begin
            if (p0 && $urandom_range(0, 99) < 4) p0 = 0;
            if (p1 && $urandom_range(0, 99) < 4) p1 = 0;
            if (!p0 && $urandom_range(0, 99) < 65) begin
                p0 = 1; w0 = 1'($urandom_range(0, 1));
                a0 = 16'(32'h10 + ($urandom_range(0, 7) << 2)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < 65) begin
                p1 = 1; w1 = 1'($urandom_range(0, 1));
                a1 = 16'(32'h10 + ($urandom_range(0, 7) << 2)); d1 = $urandom;
            end
            drive_cycle(p0, w0, a0, d0, p1, w1, a1, d1, g);
            if (g == 0) p0 = 0;
            if (g == 1) p1 = 0;
        end
        idle_cycles(4);
        @(posedge clock);
        #1;
        chk("rq0_drained", 32'(rq0.size()), 32'd0);
        chk("rq1_drained", 32'(rq1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
